fragment_arbiter: RTL and testbench
===================================

// Module: fragment_arbiter
// PURPOSE
//  Merges fragment streams from NUM_LANES parallel rasterizer lanes into the single fragment_shader input.
//  Sequences one frame per frame_start_in: arbitrates lanes, counts fragments, collects per-lane done.
//  Pulses frame_done_out once every lane is done and the output register has drained.
//  Sits between the rasterizer lanes and fragment_shader. The shader consumes one fragment per cycle,
//  gated here by stall_in from the framebuffer side.
// PARAMETERS
//  NUM_LANES  4   number of rasterizer lanes (2..8)
//  CNT_W      24  width of frag_count_out
// PORTS
//  clk_in            in   1               system clock; single clock domain
//  rst_in            in   1               reset, synchronous, active-low
//  frame_start_in    in   1               pulse: begin a frame
//  lane_valid_in     in   NUM_LANES       per-lane fragment valid
//  lane_ready_out    out  NUM_LANES       per-lane accept; transfer = valid & ready
//  lane_tri_id_in    in   NUM_LANES x 16  per-lane triangle id
//  lane_frag_in      in   NUM_LANES x 3x17  per-lane {x,y,z} fixed-point fragment
//  lane_done_in      in   NUM_LANES       pulse: lane has sent its last fragment
//  stall_in          in   1               downstream busy; hold the output
//  valid_out         out  1               fragment valid to fragment_shader
//  triangle_id_out   out  16              registered triangle id
//  fragment_out      out  3x17            registered fragment
//  busy_out          out  1               high in RUN or DRAIN
//  frame_done_out    out  1               1-cycle pulse at end of frame
//  frag_count_out    out  CNT_W           fragments accepted this frame; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_in==0 at posedge):
//   - state=IDLE; done mask=0; RR pointer=0; frag_count_out=0.
//   - valid_out=0, busy_out=0, frame_done_out=0; triangle_id_out and fragment_out = 0.
//   - Reset mid-frame abandons the frame; no frame_done_out pulse is produced.
//  States:
//   - IDLE: lane_ready_out=0. frame_start_in -> RUN; clear done mask and frag_count_out; RR pointer=0.
//   - RUN: arbitrate every cycle stall_in==0. lane_done_in[i] sets done[i] (sticky).
//     When done mask is all-ones (including the bit set this cycle) -> DRAIN.
//   - DRAIN: lane_ready_out=0. When valid_out==0, or stall_in==0 (the output is consumed) -> DONE.
//   - DONE: frame_done_out=1 for exactly this cycle; valid_out=0 -> IDLE.
//   - frame_start_in outside IDLE is ignored.
//  Arbitration (RUN, stall_in==0):
//   - At most one lane granted per cycle.
//   - Round-robin: search starts at the lane after the last granted lane and wraps NUM_LANES-1 -> 0.
//   - lane_ready_out = onehot grant. It is combinational from lane_valid_in, pointer, stall_in and state.
//   - A granted lane's fragment is registered into the output. valid_out=1 the next cycle (latency 1).
//   - The RR pointer advances only on a transfer.
//   - valid & done on the same cycle: the fragment is accepted and done is recorded.
//   - Done lanes that are still valid continue to be served until DRAIN.
//  Stall:
//   - stall_in==1: lane_ready_out=0; valid_out and data hold their values.
//   - stall_in==0 with no grant: valid_out<=0 next cycle.
//  Counter: frag_count_out increments by 1 per transfer; it holds at 2^CNT_W-1.
// CONFIGURATION
//  FRAG_ARB_FIXED_PRIO_EN
//   - defined: fixed priority; the lowest-index valid lane always wins; the RR pointer is removed.
//   - undefined (default): round-robin as above.
// STRUCTURE
//  graphics_pkg:
//   - fragment_t (logic [2:0][16:0]), TRI_ID_W=16.
//   - arb_state_t enum {IDLE,RUN,DRAIN,DONE}.
//  Sub-module rr_arbiter (NUM_LANES req -> onehot grant, pointer update on accept).
//   - The fixed-priority path lives inside it under the macro.
//  The top level holds the FSM, done mask, output register and counter.
// TESTING
//  1. Reset mid-RUN (rst_in=0 one cycle) -> next cycle IDLE; valid_out=0; frag_count_out=0; no done pulse.
//  2. NUM_LANES=4, all lanes valid continuously, stall_in=0.
//     -> grants cycle 0,1,2,3,0; valid_out=1 from cycle after first grant.
//  3. Only lane 2 valid, with 5 fragments -> 5 consecutive transfers; output order preserved; frag_count_out=5.
//  4. stall_in=1 for 3 cycles while valid_out=1 -> lane_ready_out=0; output data unchanged; resumes on release.
//  5. Lanes 0..3 done, with lane 3 done together with its final fragment.
//     -> that fragment is emitted; DRAIN; frame_done_out one pulse; busy_out falls.
//  6. With FRAG_ARB_FIXED_PRIO_EN and lanes 1 and 3 always valid -> lane 1 granted every cycle.
//  Check: frag_count_out saturates when CNT_W=4 after 20 transfers -> 15.

Source files
------------

// File: rtl/graphics_pkg.sv
// Shared types for the fragment path between the rasterizer lanes and fragment_shader.
package graphics_pkg;
  localparam int TRI_ID_W = 16;
  localparam int FRAG_C_W = 17;

  // {x,y,z} fixed-point fragment coordinates
  typedef logic [2:0][FRAG_C_W-1:0] fragment_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/fragment_arbiter_rr_arbiter.sv
// One-hot lane arbiter: round-robin by default, lowest-index-wins when
// FRAG_ARB_FIXED_PRIO_EN is defined (the rotating pointer is then removed).
module rr_arbiter
  import graphics_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [NUM_LANES-1:0] req_i,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

`ifdef FRAG_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, clk_i, rst_ni, clr_i};

  always_comb begin
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (en_i && !found && req_i[i]) begin
        found     = 1'b1;
        gnt_o[i]  = 1'b1;
        gnt_idx_o = IDX_W'(i);
      end
    end
  end
`else
  // ptr_q holds the first lane to search, i.e. one past the last granted lane
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic found;
    int   idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (en_i && !found && req_i[idx]) begin
        found     = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (|gnt_o) begin
      ptr_d = (gnt_idx_o == IDX_W'(NUM_LANES - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/fragment_arbiter.sv
// Merges NUM_LANES rasterizer lane streams into one registered fragment stream per frame.
// Build option FRAG_ARB_FIXED_PRIO_EN selects fixed-priority arbitration in rr_arbiter.
module fragment_arbiter
  import graphics_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int CNT_W     = 24,
  localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                frame_start_in,
  input  logic [NUM_LANES-1:0]                lane_valid_in,
  output logic [NUM_LANES-1:0]                lane_ready_out,
  input  logic [NUM_LANES-1:0][TRI_ID_W-1:0]  lane_tri_id_in,
  input  fragment_t [NUM_LANES-1:0]           lane_frag_in,
  input  logic [NUM_LANES-1:0]                lane_done_in,
  input  logic                                stall_in,
  output logic                                valid_out,
  output logic [TRI_ID_W-1:0]                 triangle_id_out,
  output fragment_t                           fragment_out,
  output logic                                busy_out,
  output logic                                frame_done_out,
  output logic [CNT_W-1:0]                    frag_count_out
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  arb_state_t             state_q, state_d;
  logic [NUM_LANES-1:0]   done_q, done_d;
  logic                   valid_q, valid_d;
  logic [TRI_ID_W-1:0]    tri_q;
  fragment_t              frag_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_LANES-1:0]   gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   arb_en, xfer, start, done_all;

  assign start    = (state_q == IDLE) && frame_start_in;
  assign arb_en   = (state_q == RUN) && !stall_in;
  assign xfer     = |gnt;
  assign done_all = &(done_q | lane_done_in);

  rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
    .clk_i     (clk_in),
    .rst_ni    (rst_in),
    .clr_i     (start),
    .en_i      (arb_en),
    .req_i     (lane_valid_in),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (frame_start_in) begin
          state_d = RUN;
          done_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        done_d = done_q | lane_done_in;
        if (!stall_in) valid_d = xfer;
        if (xfer) cnt_d = sat_inc(cnt_q);
        if (done_all) state_d = DRAIN;
      end
      DRAIN: begin
        // the held output leaves once downstream takes it (or it was already empty)
        if (!valid_q || !stall_in) begin
          state_d = DONE;
          valid_d = 1'b0;
        end
      end
      DONE: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      done_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      tri_q   <= '0;
      frag_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (xfer) begin
        tri_q  <= lane_tri_id_in[gnt_idx];
        frag_q <= lane_frag_in[gnt_idx];
      end
    end
  end

  assign lane_ready_out  = gnt;
  assign valid_out       = valid_q;
  assign triangle_id_out = tri_q;
  assign fragment_out    = frag_q;
  assign frag_count_out  = cnt_q;
  assign busy_out        = (state_q == RUN) || (state_q == DRAIN);
  assign frame_done_out  = (state_q == DONE);

endmodule

// File: tb/tb_fragment_arbiter.sv
// Directed bench for fragment_arbiter (NUM_LANES=4, CNT_W=4 so saturation is reachable).
module tb_fragment_arbiter;
  import graphics_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      frame_start;
  logic [3:0]                lane_valid;
  logic [3:0]                lane_ready;
  logic [3:0][TRI_ID_W-1:0]  lane_tri;
  fragment_t [3:0]           lane_frag;
  logic [3:0]                lane_done;
  logic                      stall;
  logic                      vld;
  logic [TRI_ID_W-1:0]       tri_o;
  fragment_t                 frag_o;
  logic                      busy;
  logic                      fdone;
  logic [3:0]                cnt;

  int total = 0;
  int bad   = 0;

  fragment_t exp_frag;
  logic [3:0] exp_rdy;

  fragment_arbiter #(.NUM_LANES(4), .CNT_W(4)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .frame_start_in  (frame_start),
    .lane_valid_in   (lane_valid),
    .lane_ready_out  (lane_ready),
    .lane_tri_id_in  (lane_tri),
    .lane_frag_in    (lane_frag),
    .lane_done_in    (lane_done),
    .stall_in        (stall),
    .valid_out       (vld),
    .triangle_id_out (tri_o),
    .fragment_out    (frag_o),
    .busy_out        (busy),
    .frame_done_out  (fdone),
    .frag_count_out  (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; frame_start = 1'b0; lane_valid = '0; lane_done = '0; stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lane_tri[i]  = 16'h100 + 16'(i);
      lane_frag[i] = {17'(i + 1), 17'(i + 2), 17'(i + 3)};
    end
    tick(); tick();
    check("rst_vld", vld, 0);
    check("rst_busy", busy, 0);
    check("rst_done", fdone, 0);
    check("rst_cnt", cnt, 0);
    check("rst_tri", tri_o, 0);
    check("rst_frag", frag_o, 0);
    check("rst_rdy", lane_ready, 0);
    rst = 1'b1;
    tick();

    // frame A: round-robin over all lanes
    start_frame();
    check("a_busy", busy, 1);
    check("a_cnt0", cnt, 0);
    lane_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_rdy", lane_ready, 4'b0001 << (k % 4));
      tick();
      check("rr_vld", vld, 1);
      check("rr_tri", tri_o, 16'h100 + 16'(k % 4));
    end
    check("rr_cnt", cnt, 5);

    // stall holds the output and blocks grants
    stall = 1'b1;
    exp_frag = {17'd1, 17'd2, 17'd3};
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_rdy", lane_ready, 0);
      tick();
      check("st_vld", vld, 1);
      check("st_tri", tri_o, 16'h100);
      check("st_frag", frag_o, exp_frag);
    end
    check("st_cnt", cnt, 5);
    stall = 1'b0;
    #1;
    check("rel_rdy", lane_ready, 4'b0010);
    tick();
    check("rel_tri", tri_o, 16'h101);
    check("rel_cnt", cnt, 6);

    // end of frame: lane 3 finishes with its final fragment
    lane_valid = '0; lane_done = 4'b0111;
    tick();
    lane_done = '0;
    check("idle_vld", vld, 0);
    check("d3_busy", busy, 1);
    lane_tri[3] = 16'h1FF;
    lane_valid = 4'b1000; lane_done = 4'b1000;
    #1;
    check("last_rdy", lane_ready, 4'b1000);
    tick();
    lane_done = '0; lane_valid = 4'hF;
    check("dr_vld", vld, 1);
    check("dr_tri", tri_o, 16'h1FF);
    check("dr_busy", busy, 1);
    check("dr_fdone", fdone, 0);
    check("dr_cnt", cnt, 7);
    #1;
    check("dr_rdy", lane_ready, 0);
    tick();
    check("fd_pulse", fdone, 1);
    check("fd_vld", vld, 0);
    check("fd_busy", busy, 0);
    lane_valid = '0;
    tick();
    check("fd_end", fdone, 0);
    check("idle_rdy", lane_ready, 0);

    // frame B: single lane, order preserved, then reset mid-frame
    start_frame();
    lane_valid = 4'b0100;
    for (int j = 0; j < 5; j++) begin
      lane_tri[2]  = 16'h200 + 16'(j);
      lane_frag[2] = {17'(j), 17'(j * 3), 17'(j + 100)};
      exp_frag     = {17'(j), 17'(j * 3), 17'(j + 100)};
      #1;
      check("l2_rdy", lane_ready, 4'b0100);
      tick();
      check("l2_tri", tri_o, 16'h200 + 16'(j));
      check("l2_frag", frag_o, exp_frag);
    end
    lane_valid = '0;
    check("l2_cnt", cnt, 5);
    check("l2_vld", vld, 1);
    rst = 1'b0;
    tick();
    check("mr_vld", vld, 0);
    check("mr_busy", busy, 0);
    check("mr_cnt", cnt, 0);
    check("mr_done", fdone, 0);
    rst = 1'b1;
    tick();
    check("mr_done2", fdone, 0);
    check("mr_busy2", busy, 0);

    // frame C: counter saturation, then lanes 1 and 3 contend
    start_frame();
    lane_valid = 4'b0001;
    repeat (20) tick();
    lane_valid = '0;
    check("sat_cnt", cnt, 15);
    tick();
    lane_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
`ifdef FRAG_ARB_FIXED_PRIO_EN
      exp_rdy = 4'b0010;
`else
      exp_rdy = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      #1;
      check("pr_rdy", lane_ready, exp_rdy);
      tick();
    end
    check("sat_hold", cnt, 15);
    lane_valid = '0; lane_done = 4'hF;
    tick();
    lane_done = '0;
    tick();
    check("c_fdone", fdone, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
